// File: rtl/pwm_frame_pkg.sv
// Shared definitions for the PWM frame driver.
// Holds the commit FSM state type and the default parameter values used by
// pwm_frame_driver and pwm_channel.
package pwm_frame_pkg;

  localparam int unsigned DefN        = 8;
  localparam int unsigned DefMaxCount = 255;
  localparam int unsigned DefChannels = 16;
  localparam int unsigned DefAw       = 4;

  // StIdle: shadow writable, commit accepted. StPending: waiting for frame end.
  typedef enum logic [0:0] {
    StIdle,
    StPending
  } state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow and active brightness registers plus the
// registered compare against the shared frame count.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load_en_i      write wr_data_i into the shadow register
//   wr_data_i      brightness value for the shadow register
//   swap_en_i      copy shadow into active (frame boundary)
//   count_i        upstream frame count
//   blank_i        force the output low
//   pwm_o          registered LED drive
module pwm_channel
  import pwm_frame_pkg::*;
#(
  parameter int unsigned N = DefN
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en_i,
  input  logic [N-1:0] wr_data_i,
  input  logic         swap_en_i,
  input  logic [N-1:0] count_i,
  input  logic         blank_i,
  output logic         pwm_o
);

  logic [N-1:0] shadow_q, shadow_d;
  logic [N-1:0] active_q, active_d;
  logic         pwm_q, pwm_d;

  always_comb begin
    shadow_d = load_en_i ? wr_data_i : shadow_q;
    active_d = swap_en_i ? shadow_q : active_q;
    // Compare uses the active value before any swap on this edge, so a new
    // value first applies to the count following the boundary.
    pwm_d    = !blank_i && (count_i < active_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_frame_driver.sv
// Multi-channel PWM generator driven by an upstream free-running count.
// Brightness values are written into a shadow bank; a commit copies the
// shadow bank into the active bank at the next frame boundary
// (count == MAX_COUNT) so updates never tear mid-frame.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   count                          upstream count, 0..MAX_COUNT
//   wr_valid/wr_addr/wr_data       shadow write request
//   wr_ready                       shadow bank accepting writes
//   commit_valid/commit_ready      commit handshake
//   commit_done                    one-cycle pulse after the swap edge
//   blank                          force all outputs low
//   pwm                            registered LED drive, bit i = channel i
module pwm_frame_driver
  import pwm_frame_pkg::*;
#(
  parameter int unsigned N         = DefN,
  parameter int unsigned MAX_COUNT = DefMaxCount,
  parameter int unsigned CHANNELS  = DefChannels,
  parameter int unsigned AW        = DefAw
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N-1:0]        count,
  input  logic                wr_valid,
  input  logic [AW-1:0]       wr_addr,
  input  logic [N-1:0]        wr_data,
  output logic                wr_ready,
  input  logic                commit_valid,
  output logic                commit_ready,
  output logic                commit_done,
  input  logic                blank,
  output logic [CHANNELS-1:0] pwm
);

  state_e state_q, state_d;
  logic   commit_done_q, commit_done_d;
  logic   at_boundary;
  logic   wr_fire;
  logic   commit_fire;
  logic   swap;
  logic [CHANNELS-1:0] load_en;

  assign at_boundary = (count == N'(MAX_COUNT));
  assign wr_fire     = wr_valid && wr_ready;
  assign commit_fire = commit_valid && commit_ready;
  assign swap        = (state_q == StPending) && at_boundary;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_q <= commit_done_d;
    end
  end

  // Next-state logic. A commit accepted on a boundary edge only enters
  // StPending; the swap waits for the following boundary.
  always_comb begin
    state_d       = state_q;
    commit_done_d = swap;
    unique case (state_q)
      StIdle: begin
        if (commit_fire) state_d = StPending;
      end
      StPending: begin
        if (at_boundary) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    wr_ready     = 1'b0;
    commit_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
      end
      StPending: begin
        wr_ready     = 1'b0;
        commit_ready = 1'b0;
      end
      default: begin
        wr_ready     = 1'b0;
        commit_ready = 1'b0;
      end
    endcase
  end

  assign commit_done = commit_done_q;

  // Addresses at or above CHANNELS match no channel and are dropped.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    assign load_en[ch] = wr_fire && (wr_addr == AW'(ch));

    pwm_channel #(
      .N(N)
    ) u_channel (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_en_i(load_en[ch]),
      .wr_data_i(wr_data),
      .swap_en_i(swap),
      .count_i  (count),
      .blank_i  (blank),
      .pwm_o    (pwm[ch])
    );
  end

endmodule

// File: tb/tb_pwm_frame_driver.sv
module tb_pwm_frame_driver;

  localparam int CH   = 16;
  localparam int MAXC = 255;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    count = '0;
  logic          wr_valid = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_ready;
  logic          commit_valid = 1'b0;
  logic          commit_ready;
  logic          commit_done;
  logic          blank = 1'b0;
  logic [CH-1:0] pwm;

  always #5 clk = ~clk;

  pwm_frame_driver #(
    .N        (8),
    .MAX_COUNT(MAXC),
    .CHANNELS (CH),
    .AW       (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .count       (count),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .commit_valid(commit_valid),
    .commit_ready(commit_ready),
    .commit_done (commit_done),
    .blank       (blank),
    .pwm         (pwm)
  );

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          done;
    logic          wrdy;
    logic          crdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   pushes = 0;
  int   pops   = 0;

  // Reference model: brightness banks as plain arrays, a pending-commit flag,
  // and the upstream count to present next.
  int shadow_m[CH];
  int active_m[CH];
  bit pending_m;
  int cnt_m;

  logic [CH-1:0] s_pwm;
  logic          s_done;
  logic          s_wrdy;
  int            hc[CH];
  int            dc;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a registered output, compare it
  // with the oldest expectation.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      pops++;
      chk("pwm", int'(pwm), int'(mon_e.pwm));
      chk("commit_done", int'(commit_done), int'(mon_e.done));
      chk("wr_ready", int'(wr_ready), int'(mon_e.wrdy));
      chk("commit_ready", int'(commit_ready), int'(mon_e.crdy));
    end
  end

  task automatic step(input bit wv, input int wa, input int wd, input bit cv, input bit bl);
    exp_t e;
    bit   swap;
    @(negedge clk);
    wr_valid     = wv;
    wr_addr      = wa[3:0];
    wr_data      = wd[7:0];
    commit_valid = cv;
    blank        = bl;
    count        = cnt_m[7:0];
    for (int i = 0; i < CH; i++) e.pwm[i] = !bl && (cnt_m < active_m[i]);
    swap   = pending_m && (cnt_m == MAXC);
    e.done = swap;
    if (!pending_m && wv && wa < CH) shadow_m[wa] = wd;
    if (swap) for (int i = 0; i < CH; i++) active_m[i] = shadow_m[i];
    if (!pending_m && cv) pending_m = 1'b1;
    else if (swap) pending_m = 1'b0;
    e.wrdy = !pending_m;
    e.crdy = !pending_m;
    exp_q.push_back(e);
    pushes++;
    cnt_m = (cnt_m == MAXC) ? 0 : cnt_m + 1;
    @(posedge clk);
    #1;
    s_pwm  = pwm;
    s_done = commit_done;
    s_wrdy = wr_ready;
  endtask

  task automatic run_to(input int c);
    for (int k = 0; k < 300 && cnt_m != c; k++) step(0, 0, 0, 0, 0);
    chk("run_to_reached", cnt_m, c);
  endtask

  // One full frame of idle stimulus, tallying high cycles per channel.
  task automatic frame();
    for (int i = 0; i < CH; i++) hc[i] = 0;
    dc = 0;
    for (int k = 0; k <= MAXC; k++) begin
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < CH; i++) if (s_pwm[i]) hc[i]++;
      if (s_done) dc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_pwm_now", int'(pwm), 0);
    chk("reset_done_now", int'(commit_done), 0);
    for (int i = 0; i < CH; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end
    pending_m = 1'b0;
    cnt_m     = 0;
    wr_valid = 1'b0; commit_valid = 1'b0; blank = 1'b0; count = '0;
    repeat (2) @(negedge clk);
    chk("reset_pwm_held", int'(pwm), 0);
    reset_n = 1'b1;
  endtask

  int low;

  initial begin
    do_reset();

    // Basic brightness levels and a mid-frame commit.
    step(1, 0, 4, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 2, 255, 0, 0);
    run_to(10);
    step(0, 0, 0, 1, 0);
    run_to(MAXC);
    step(0, 0, 0, 0, 0);
    chk("done_after_swap", int'(s_done), 1);
    frame();
    chk("ch0_high_cycles", hc[0], 4);
    chk("ch1_high_cycles", hc[1], 0);
    chk("ch2_high_cycles", hc[2], 255);
    chk("done_pulse_once", dc, 0);

    // Commit on a boundary waits a full frame; writes stall meanwhile.
    run_to(MAXC);
    step(0, 0, 0, 1, 0);
    low = s_wrdy ? 0 : 1;
    for (int k = 0; k < MAXC; k++) begin
      step(1, 3, 9, 0, 0);
      if (!s_wrdy) low++;
    end
    chk("no_swap_before_boundary", int'(s_done), 0);
    step(1, 3, 9, 0, 0);
    chk("done_full_frame_later", int'(s_done), 1);
    chk("wr_ready_low_cycles", low, 256);
    step(1, 3, 9, 0, 0);
    frame();
    chk("ch3_unchanged_after_swap", hc[3], 0);

    // Same-edge write and commit: the write is part of the swap.
    run_to(20);
    step(1, 5, 7, 1, 0);
    run_to(MAXC);
    step(0, 0, 0, 0, 0);
    frame();
    chk("ch5_high_cycles", hc[5], 7);
    chk("ch3_high_cycles", hc[3], 9);

    // Blank mid-frame.
    run_to(2);
    step(0, 0, 0, 0, 1);
    chk("blank_all_low", int'(s_pwm), 0);
    step(0, 0, 0, 0, 0);
    chk("unblank_ch2", int'(s_pwm[2]), 1);

    // Reset while a commit is pending.
    run_to(100);
    step(1, 6, 200, 1, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    chk("pending_before_reset", int'(s_wrdy), 0);
    do_reset();
    frame();
    chk("post_reset_done", dc, 0);
    chk("post_reset_ch2", hc[2], 0);
    chk("post_reset_ch6", hc[6], 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, CH - 1)),
           int'($urandom_range(0, 255)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    chk("queue_drained", pops, pushes);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
